// File: rtl/acc_pkg.sv
// Shared constants, FSM state type and cfg helpers for the partial-sum accumulator sequencer.
package acc_pkg;

    localparam int unsigned DW      = 32;
    localparam int unsigned DP      = 56;
    localparam int unsigned ACC_LAT = 3;
    localparam int unsigned GRP_W   = 8;
    localparam int unsigned ROW_W   = 8;
    localparam int unsigned VW      = DW * DP;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // A zero count is treated as one so a tile always makes progress.
    function automatic logic [GRP_W-1:0] grp_num_norm(input logic [GRP_W-1:0] n);
        return (n == '0) ? GRP_W'(1) : n;
    endfunction

    function automatic logic [ROW_W-1:0] row_num_norm(input logic [ROW_W-1:0] n);
        return (n == '0) ? ROW_W'(1) : n;
    endfunction

endpackage

// File: rtl/acc_tag_pipe.sv
// Tracks each issued beat's {vld, first, last} tags through the accumulator latency.
module acc_tag_pipe
    import acc_pkg::*;
#(
    parameter int unsigned DEPTH = ACC_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_vld,
    input  logic issue_first,
    input  logic issue_last,
    output logic s0_first,
    output logic res_vld,
    output logic res_first,
    output logic res_last,
    output logic last_inflight
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] first_q, first_d;
    logic [DEPTH-1:0] last_q, last_d;

    // Tags are qualified by vld on entry so idle slots never carry stale first/last.
    always_comb begin
        vld_d   = {vld_q[DEPTH-2:0], issue_vld};
        first_d = {first_q[DEPTH-2:0], issue_vld & issue_first};
        last_d  = {last_q[DEPTH-2:0], issue_vld & issue_last};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign s0_first      = vld_q[0] & first_q[0];
    assign res_vld       = vld_q[DEPTH-1];
    assign res_first     = first_q[DEPTH-1];
    assign res_last      = last_q[DEPTH-1];
    assign last_inflight = |(vld_q & last_q);

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequences group beats through the 3-stage accumulator per output row, keeps the running
// row psum, gates the 1x1/identity branch to first groups and presents finished rows.
module acc_seq_ctrl
    import acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [GRP_W-1:0] cfg_grp_num,
    input  logic [ROW_W-1:0] cfg_row_num,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VW-1:0]    conv_res_i,
    output logic [VW-1:0]    conv_res_o,
    input  logic [VW-1:0]    acc_res_i,
    output logic [VW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    state_e state_q, state_d;

    logic [GRP_W-1:0] grp_num_q, grp_num_d;
    logic [GRP_W-1:0] grp_cnt_q, grp_cnt_d;
    logic [ROW_W-1:0] row_num_q, row_num_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [VW-1:0]    psum_q, psum_d;
    logic [VW-1:0]    out_data_q, out_data_d;
    logic [VW-1:0]    sum_w;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic issue, tag_first, tag_last, row_last, out_stalled, final_accept;
    logic s0_first, res_vld, res_first, res_last, last_inflight;

    assign tag_first    = (grp_cnt_q == '0);
    assign tag_last     = (grp_cnt_q == grp_num_q - GRP_W'(1));
    assign row_last     = (row_cnt_q == row_num_q - ROW_W'(1));
    assign out_stalled  = out_valid_q & ~out_ready;
    assign issue        = in_valid & in_ready;
    // Only one last can be in flight, so once the pipe holds none the out register owns the final row.
    assign final_accept = (state_q == DRAIN) & out_valid_q & out_ready & ~last_inflight;

    acc_tag_pipe #(
        .DEPTH(ACC_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_vld    (issue),
        .issue_first  (tag_first),
        .issue_last   (tag_last),
        .s0_first     (s0_first),
        .res_vld      (res_vld),
        .res_first    (res_first),
        .res_last     (res_last),
        .last_inflight(last_inflight)
    );

    for (genvar l = 0; l < DP; l++) begin : g_lane
        assign sum_w[l*DW +: DW] = (res_first ? '0 : psum_q[l*DW +: DW]) + acc_res_i[l*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issue && tag_last && row_last) state_d = DRAIN;
            DRAIN:   if (final_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A last beat waits until no other last is in flight and the out register cannot be stuck.
    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        if (state_q == RUN) begin
            in_ready = ~tag_last | (~last_inflight & ~out_stalled);
        end
    end

    always_comb begin
        grp_num_d   = grp_num_q;
        row_num_d   = row_num_q;
        grp_cnt_d   = grp_cnt_q;
        row_cnt_d   = row_cnt_q;
        psum_d      = psum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = final_accept;

        if (state_q == IDLE && start) begin
            grp_num_d = grp_num_norm(cfg_grp_num);
            row_num_d = row_num_norm(cfg_row_num);
            grp_cnt_d = '0;
            row_cnt_d = '0;
        end else if (issue) begin
            grp_cnt_d = tag_last ? '0 : grp_cnt_q + GRP_W'(1);
            if (tag_last) begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
            end
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (res_vld) begin
            if (res_last) begin
                out_data_d  = sum_w;
                out_valid_d = 1'b1;
            end else begin
                psum_d = sum_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_num_q   <= '0;
            row_num_q   <= '0;
            grp_cnt_q   <= '0;
            row_cnt_q   <= '0;
            psum_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            grp_num_q   <= grp_num_d;
            row_num_q   <= row_num_d;
            grp_cnt_q   <= grp_cnt_d;
            row_cnt_q   <= row_cnt_d;
            psum_q      <= psum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign conv_res_o = s0_first ? conv_res_i : '0;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;

endmodule
